mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory unit port (address / write data / access control / write enable / read enable / read data) between two requesters: the instruction-fetch port (read-only) and the load/store data port.
- Arbitrates between them, latches the winning request, sequences the memory access over a fixed latency, and returns a one-cycle ready pulse with read data.
- Sits between the core's fetch and LSU stages and the memory unit; the core stalls on a requester until its ready pulse.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDRESS_WIDTH, 32, byte address width.
- MEM_LATENCY, 2, cycles read enable is held before read data is sampled; legal range 1..15.
- INSTR_CTRL, 3'b010, access-control code driven for instruction fetches (word access).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_req  in  1  fetch request; held until instr_ready.
- instr_addr  in  ADDRESS_WIDTH  fetch byte address.
- instr_rdata  out  DATA_WIDTH  fetched word; valid while instr_ready=1.
- instr_ready  out  1  one-cycle completion pulse.
- data_req  in  1  load/store request; held until data_ready.
- data_we  in  1  1=store, 0=load.
- data_addr  in  ADDRESS_WIDTH  load/store byte address.
- data_wdata  in  DATA_WIDTH  store data.
- data_ctrl  in  3  access-control code (byte/half/word, sign).
- data_rdata  out  DATA_WIDTH  load result; valid while data_ready=1.
- data_ready  out  1  one-cycle completion pulse.
- mem_address  out  ADDRESS_WIDTH  to memory unit.
- mem_write_data  out  DATA_WIDTH  to memory unit.
- mem_DATAMEMControl  out  3  to memory unit.
- mem_write_enable  out  1  to memory unit.
- mem_read_en  out  1  to memory unit.
- mem_read_data  in  DATA_WIDTH  from memory unit.

Behaviour:
- **Reset.** On rst (async), all outputs go to 0, state=IDLE, last_grant=DATA (so the first conflict goes to instr), and the counter is cleared.
- **Reset mid-access.** The access is abandoned immediately. No ready pulse is produced. mem_write_enable drops at once. A store already issued in a previous cycle is not undone.
- **Output timing.** All outputs are registered.
- **State machine:** IDLE, ACCESS, RESP.
- **IDLE.**
  - Requests are sampled only in this state.
  - If none is pending, the block stays in IDLE.
  - If exactly one is pending, it is granted.
  - If both are pending, round-robin applies: grant the requester not in last_grant.
  - On a grant: latch address, wdata, control (INSTR_CTRL for instr) and we (0 for instr); update last_grant; load counter = MEM_LATENCY-1; go to ACCESS.
- **ACCESS.** mem_* outputs are driven from the latched values and remain stable throughout.
  - Load or fetch: mem_read_en=1 in every ACCESS cycle. Decrement the counter. When counter==0, capture mem_read_data into the granted requester's rdata register and go to RESP.
  - Store: mem_write_enable=1 for exactly the first ACCESS cycle, mem_read_en=0. Go to RESP after 1 cycle regardless of MEM_LATENCY.
- **RESP.**
  - Ready=1 for the granted requester only, for one cycle. mem_read_en=0, mem_write_enable=0.
  - Go to IDLE.
  - A request still high during RESP is treated as a new request in the following IDLE cycle.
- **Latency from request to ready** (request sampled in IDLE):
  - Read: MEM_LATENCY+2 cycles.
  - Store: 3 cycles.
- **Read data registers.** instr_rdata and data_rdata hold their value until the next capture for that port. data_rdata is not updated by stores.
- **Requester protocol.** A requester that drops req before ready is a protocol violation. The arbiter still completes the latched access and pulses ready.
- **Idle bus values.** In IDLE and RESP, mem_address, mem_write_data and mem_DATAMEMControl hold their last values. The enables are 0.
- **Unused inputs.** data_ctrl and data_wdata are ignored for loads except for latching.

Optional Feature:
- **Macro:** MEMARB_DATA_PRIO_EN.
- **Defined:** fixed priority. data_req always wins a conflict; last_grant is unused and the fetch can be starved.
- **Undefined (default):** round-robin as above.

Test Plan (MEM_LATENCY=2 unless stated):
1. Reset, then instr_req=1, instr_addr=0x10, mem_read_data=0xDEADBEEF.
   - mem_read_en=1 for exactly 2 cycles.
   - instr_ready pulses 4 cycles after the request is sampled, with instr_rdata=0xDEADBEEF.
   - mem_DATAMEMControl=3'b010.
2. data store, addr=0x20, wdata=0x12345678, ctrl=3'b010.
   - mem_write_enable high for exactly 1 cycle with mem_address=0x20 and mem_write_data=0x12345678.
   - data_ready 3 cycles after the request is sampled.
   - data_rdata unchanged.
3. Both requests high continuously from reset.
   - Grants alternate instr, data, instr, data.
   - Each ready pulse is on its own port only, never both in one cycle.
4. Assert rst in the 2nd ACCESS cycle of a load.
   - All outputs go to 0 immediately and no data_ready appears.
   - After release, a fresh data_req completes normally.
5. MEM_LATENCY=1: a load completes in 3 cycles with mem_read_en high for 1 cycle.
   - MEM_LATENCY=5: mem_read_en high for 5 cycles, ready after 7 cycles.
6. With MEMARB_DATA_PRIO_EN, both requests held high.
   - data is granted every arbitration and instr_ready never pulses.
   - Dropping data_req lets instr complete.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-unit signals around the arbiter.
// slave: arbiter side; master: requesters plus memory unit side.
interface mem_port_arbiter_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic                     instr_req;
   logic [ADDRESS_WIDTH-1:0] instr_addr;
   logic [DATA_WIDTH-1:0]    instr_rdata;
   logic                     instr_ready;
   logic                     data_req;
   logic                     data_we;
   logic [ADDRESS_WIDTH-1:0] data_addr;
   logic [DATA_WIDTH-1:0]    data_wdata;
   logic [2:0]               data_ctrl;
   logic [DATA_WIDTH-1:0]    data_rdata;
   logic                     data_ready;
   logic [ADDRESS_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0]    mem_write_data;
   logic [2:0]               mem_DATAMEMControl;
   logic                     mem_write_enable;
   logic                     mem_read_en;
   logic [DATA_WIDTH-1:0]    mem_read_data;

   modport slave (
      input  instr_req, instr_addr,
      output instr_rdata, instr_ready,
      input  data_req, data_we, data_addr, data_wdata, data_ctrl,
      output data_rdata, data_ready,
      output mem_address, mem_write_data, mem_DATAMEMControl,
      output mem_write_enable, mem_read_en,
      input  mem_read_data
   );

   modport master (
      output instr_req, instr_addr,
      input  instr_rdata, instr_ready,
      output data_req, data_we, data_addr, data_wdata, data_ctrl,
      input  data_rdata, data_ready,
      input  mem_address, mem_write_data, mem_DATAMEMControl,
      input  mem_write_enable, mem_read_en,
      output mem_read_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and load/store.
// Optional macro MEMARB_DATA_PRIO_EN: data wins every conflict (else round-robin).
module mem_port_arbiter #(
   parameter int         DATA_WIDTH    = 32,
   parameter int         ADDRESS_WIDTH = 32,
   parameter int         MEM_LATENCY   = 2,
   parameter logic [2:0] INSTR_CTRL    = 3'b010
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   state_t     state;
   logic       sel_data;
   logic [3:0] cnt;
   logic       grant_instr;
   logic       grant_data;

`ifdef MEMARB_DATA_PRIO_EN
   // Fixed priority: load/store always beats fetch.
   always_comb begin
      grant_data  = bus.data_req;
      grant_instr = bus.instr_req & ~bus.data_req;
   end
`else
   logic last_data;

   // Round-robin: on a conflict the requester not served last wins.
   always_comb begin
      grant_data  = bus.data_req;
      grant_instr = bus.instr_req;
      if (bus.instr_req && bus.data_req) begin
         grant_data  = ~last_data;
         grant_instr = last_data;
      end
   end

   // Remember who was granted last; reset favours fetch first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_data <= 1'b1;
      else if (state == IDLE && (grant_instr || grant_data))
         last_data <= grant_data;
   end
`endif

   // Arbitration, access sequencing and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= IDLE;
         sel_data               <= 1'b0;
         cnt                    <= '0;
         bus.instr_rdata        <= '0;
         bus.instr_ready        <= 1'b0;
         bus.data_rdata         <= '0;
         bus.data_ready         <= 1'b0;
         bus.mem_address        <= '0;
         bus.mem_write_data     <= '0;
         bus.mem_DATAMEMControl <= '0;
         bus.mem_write_enable   <= 1'b0;
         bus.mem_read_en        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_data) begin
                  sel_data               <= 1'b1;
                  bus.mem_address        <= bus.data_addr;
                  bus.mem_write_data     <= bus.data_wdata;
                  bus.mem_DATAMEMControl <= bus.data_ctrl;
                  bus.mem_write_enable   <= bus.data_we;
                  bus.mem_read_en        <= ~bus.data_we;
                  cnt                    <= LAT_M1;
                  state                  <= ACCESS;
               end else if (grant_instr) begin
                  sel_data               <= 1'b0;
                  bus.mem_address        <= bus.instr_addr;
                  bus.mem_DATAMEMControl <= INSTR_CTRL;
                  bus.mem_write_enable   <= 1'b0;
                  bus.mem_read_en        <= 1'b1;
                  cnt                    <= LAT_M1;
                  state                  <= ACCESS;
               end
            end
            ACCESS: begin
               if (bus.mem_write_enable) begin
                  bus.mem_write_enable <= 1'b0;
                  bus.data_ready       <= 1'b1;
                  state                <= RESP;
               end else if (cnt == 4'd0) begin
                  bus.mem_read_en <= 1'b0;
                  if (sel_data) begin
                     bus.data_rdata <= bus.mem_read_data;
                     bus.data_ready <= 1'b1;
                  end else begin
                     bus.instr_rdata <= bus.mem_read_data;
                     bus.instr_ready <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               bus.instr_ready <= 1'b0;
               bus.data_ready  <= 1'b0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus corner sequences.
// Three instances share stimulus to cover MEM_LATENCY of 1, 2 and 5.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_req = 1'b0;
   logic [31:0] instr_addr = '0;
   logic        data_req = 1'b0;
   logic        data_we = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [2:0]  data_ctrl = '0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if if1 ();
   mem_port_arbiter_if if2 ();
   mem_port_arbiter_if if5 ();

   assign if1.instr_req = instr_req;  assign if1.instr_addr = instr_addr;
   assign if1.data_req = data_req;    assign if1.data_we = data_we;
   assign if1.data_addr = data_addr;  assign if1.data_wdata = data_wdata;
   assign if1.data_ctrl = data_ctrl;  assign if1.mem_read_data = mem_rdata;
   assign if2.instr_req = instr_req;  assign if2.instr_addr = instr_addr;
   assign if2.data_req = data_req;    assign if2.data_we = data_we;
   assign if2.data_addr = data_addr;  assign if2.data_wdata = data_wdata;
   assign if2.data_ctrl = data_ctrl;  assign if2.mem_read_data = mem_rdata;
   assign if5.instr_req = instr_req;  assign if5.instr_addr = instr_addr;
   assign if5.data_req = data_req;    assign if5.data_we = data_we;
   assign if5.data_addr = data_addr;  assign if5.data_wdata = data_wdata;
   assign if5.data_ctrl = data_ctrl;  assign if5.mem_read_data = mem_rdata;

   mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   mem_port_arbiter #(.MEM_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   mem_port_arbiter #(.MEM_LATENCY(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

   typedef struct {
      string       name;
      logic        is_instr;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  ctrl;
      logic [31:0] mrd;
      int          exp_lat;
      int          exp_ren;
      int          exp_wen;
      logic [2:0]  exp_ctrl;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mkv(string n, logic ii, logic w, logic [31:0] a,
                                logic [31:0] wd, logic [2:0] c, logic [31:0] m,
                                int l, int re, int we_n, logic [2:0] ec,
                                logic [31:0] er);
      vec_t v;
      v.name = n; v.is_instr = ii; v.we = w; v.addr = a; v.wdata = wd;
      v.ctrl = c; v.mrd = m; v.exp_lat = l; v.exp_ren = re; v.exp_wen = we_n;
      v.exp_ctrl = ec; v.exp_rdata = er;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      instr_req = 1'b0;
      data_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Single request on the MEM_LATENCY=2 instance; lat counts the request
   // cycle as 1 and stops at the cycle where ready is seen (-1 on timeout).
   task automatic run_vec(input vec_t v, output int lat, output int ren,
                          output int wen, output int other,
                          output logic bad_a, output logic bad_c,
                          output logic bad_w);
      logic done;
      done = 1'b0;
      lat = 1; ren = 0; wen = 0; other = 0;
      bad_a = 1'b0; bad_c = 1'b0; bad_w = 1'b0;
      @(negedge clk);
      mem_rdata = v.mrd;
      data_ctrl = v.ctrl;
      if (v.is_instr) begin
         instr_addr = v.addr;
         instr_req = 1'b1;
      end else begin
         data_addr = v.addr;
         data_wdata = v.wdata;
         data_we = v.we;
         data_req = 1'b1;
      end
      for (int k = 0; k < 40 && !done; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (if2.mem_read_en) ren++;
         if (if2.mem_write_enable) begin
            wen++;
            if (if2.mem_write_data !== v.wdata) bad_w = 1'b1;
         end
         if (if2.mem_read_en || if2.mem_write_enable) begin
            if (if2.mem_address !== v.addr) bad_a = 1'b1;
            if (if2.mem_DATAMEMControl !== v.exp_ctrl) bad_c = 1'b1;
         end
         if (v.is_instr ? if2.data_ready : if2.instr_ready) other++;
         if (v.is_instr ? if2.instr_ready : if2.data_ready) done = 1'b1;
      end
      instr_req = 1'b0;
      data_req = 1'b0;
      if (!done) lat = -1;
   endtask

   initial begin
      int lat, ren, wen, other;
      logic ba, bc, bw;
      logic [31:0] exp_i, exp_d;
      int order[4];
      int np, both, icnt, dcnt, igrant;
      logic found;
      int r1, r5, l1, l5;

      vecs[0] = mkv("fetch",  1, 0, 32'h10, 32'h0,        3'b111, 32'hDEADBEEF,
                    4, 2, 0, 3'b010, 32'hDEADBEEF);
      vecs[1] = mkv("lbu",    0, 0, 32'h40, 32'h0,        3'b100, 32'h000000AB,
                    4, 2, 0, 3'b100, 32'h000000AB);
      vecs[2] = mkv("sw",     0, 1, 32'h20, 32'h12345678, 3'b010, 32'hFFFFFFFF,
                    3, 0, 1, 3'b010, 32'h000000AB);
      vecs[3] = mkv("fetch2", 1, 0, 32'h14, 32'h0,        3'b000, 32'h00500093,
                    4, 2, 0, 3'b010, 32'h00500093);
      vecs[4] = mkv("sb",     0, 1, 32'h23, 32'h000000A5, 3'b000, 32'h11111111,
                    3, 0, 1, 3'b000, 32'h000000AB);
      vecs[5] = mkv("lh",     0, 0, 32'h22, 32'h0,        3'b001, 32'hFFFF8001,
                    4, 2, 0, 3'b001, 32'hFFFF8001);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_instr_ready", 32'(if2.instr_ready), 0);
      chk("rst_data_ready", 32'(if2.data_ready), 0);
      chk("rst_instr_rdata", if2.instr_rdata, 0);
      chk("rst_data_rdata", if2.data_rdata, 0);
      chk("rst_mem_address", if2.mem_address, 0);
      chk("rst_mem_wdata", if2.mem_write_data, 0);
      chk("rst_mem_ctrl", 32'(if2.mem_DATAMEMControl), 0);
      chk("rst_mem_we", 32'(if2.mem_write_enable), 0);
      chk("rst_mem_re", 32'(if2.mem_read_en), 0);
      @(negedge clk);
      rst = 1'b0;

      // Table of single transactions
      exp_i = '0;
      exp_d = '0;
      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], lat, ren, wen, other, ba, bc, bw);
         if (vecs[i].is_instr) exp_i = vecs[i].exp_rdata;
         else exp_d = vecs[i].exp_rdata;
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
         chk({vecs[i].name, "_ren"}, 32'(ren), 32'(vecs[i].exp_ren));
         chk({vecs[i].name, "_wen"}, 32'(wen), 32'(vecs[i].exp_wen));
         chk({vecs[i].name, "_other_ready"}, 32'(other), 0);
         chk({vecs[i].name, "_addr_bad"}, 32'(ba), 0);
         chk({vecs[i].name, "_ctrl_bad"}, 32'(bc), 0);
         chk({vecs[i].name, "_wdata_bad"}, 32'(bw), 0);
         chk({vecs[i].name, "_instr_rdata"}, if2.instr_rdata, exp_i);
         chk({vecs[i].name, "_data_rdata"}, if2.data_rdata, exp_d);
         @(negedge clk);
      end

`ifdef MEMARB_DATA_PRIO_EN
      // Both requests held: data always wins, fetch starves
      @(negedge clk);
      rst = 1'b1;
      instr_addr = 32'h100; data_addr = 32'h200; data_we = 1'b0;
      data_ctrl = 3'b010; mem_rdata = 32'h0BADF00D;
      instr_req = 1'b1; data_req = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      icnt = 0; dcnt = 0; igrant = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (if2.instr_ready) icnt++;
         if (if2.data_ready) dcnt++;
         if (if2.mem_read_en && if2.mem_address == 32'h100) igrant++;
      end
      chk("prio_instr_ready_cnt", 32'(icnt), 0);
      chk("prio_instr_grants", 32'(igrant), 0);
      chk("prio_data_ready_ge8", 32'(dcnt >= 8), 1);
      @(negedge clk);
      data_req = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         if (if2.instr_ready) found = 1'b1;
      end
      instr_req = 1'b0;
      chk("prio_instr_completes", 32'(found), 1);
      chk("prio_instr_rdata", if2.instr_rdata, 32'h0BADF00D);
`else
      // Both requests held from reset: strict alternation starting with fetch
      @(negedge clk);
      rst = 1'b1;
      instr_addr = 32'h100; data_addr = 32'h200; data_we = 1'b0;
      data_ctrl = 3'b010; mem_rdata = 32'h0BADF00D;
      instr_req = 1'b1; data_req = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      np = 0; both = 0;
      for (int k = 0; k < 4; k++) order[k] = 9;
      for (int k = 0; k < 60 && np < 4; k++) begin
         @(posedge clk);
         #1;
         if (if2.instr_ready && if2.data_ready) both++;
         if (if2.instr_ready) begin
            order[np] = 0; np++;
         end else if (if2.data_ready) begin
            order[np] = 1; np++;
         end
      end
      instr_req = 1'b0;
      data_req = 1'b0;
      chk("rr_grant0_instr", 32'(order[0]), 0);
      chk("rr_grant1_data", 32'(order[1]), 1);
      chk("rr_grant2_instr", 32'(order[2]), 0);
      chk("rr_grant3_data", 32'(order[3]), 1);
      chk("rr_both_ready", 32'(both), 0);
`endif

      // Reset in the second ACCESS cycle of a load
      do_reset();
      @(negedge clk);
      data_addr = 32'h80; data_we = 1'b0; data_ctrl = 3'b010;
      mem_rdata = 32'hCAFEF00D;
      data_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_rst_pre_re", 32'(if2.mem_read_en), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_re", 32'(if2.mem_read_en), 0);
      chk("mid_rst_addr", if2.mem_address, 0);
      chk("mid_rst_ctrl", 32'(if2.mem_DATAMEMControl), 0);
      chk("mid_rst_data_ready", 32'(if2.data_ready), 0);
      data_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (if2.data_ready) dcnt++;
      end
      chk("mid_rst_no_ready", 32'(dcnt), 0);
      chk("mid_rst_rdata", if2.data_rdata, 0);
      run_vec(mkv("after_rst", 0, 0, 32'h84, 32'h0, 3'b010, 32'h55AA55AA,
                  4, 2, 0, 3'b010, 32'h55AA55AA),
              lat, ren, wen, other, ba, bc, bw);
      chk("after_rst_lat", 32'(lat), 4);
      chk("after_rst_ren", 32'(ren), 2);
      chk("after_rst_rdata", if2.data_rdata, 32'h55AA55AA);

      // Latency 1 and 5 instances on a common load
      do_reset();
      @(negedge clk);
      data_addr = 32'h300; data_we = 1'b0; data_ctrl = 3'b010;
      mem_rdata = 32'h13579BDF;
      data_req = 1'b1;
      r1 = 0; r5 = 0; l1 = -1; l5 = -1;
      for (int n = 2; n < 22; n++) begin
         @(posedge clk);
         #1;
         if (l1 < 0 && if1.mem_read_en) r1++;
         if (l5 < 0 && if5.mem_read_en) r5++;
         if (l1 < 0 && if1.data_ready) l1 = n;
         if (l5 < 0 && if5.data_ready) l5 = n;
         if (n == 3) chk("lat1_rdata", if1.data_rdata, 32'h13579BDF);
         if (n == 7) chk("lat5_rdata", if5.data_rdata, 32'h13579BDF);
      end
      data_req = 1'b0;
      chk("lat1_ren", 32'(r1), 1);
      chk("lat1_ready_cycle", 32'(l1), 3);
      chk("lat5_ren", 32'(r5), 5);
      chk("lat5_ready_cycle", 32'(l5), 7);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
